// File: rtl/baccarat_sequencer.sv
// baccarat_sequencer: Moore FSM that paces one Punto Banco hand. It issues one
// card-load strobe per slow_clock cycle, applies the third-card drawing rules
// to the datapath scores, and drives the win lights once the hand is complete.
module baccarat_sequencer (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_EVAL,
        S_P3,
        S_CHK3,
        S_D3,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Face cards, tens and the unused codes 0/14/15 all count as zero points.
    logic [3:0] p3_val;
    logic       dealer_draws;

    // Point value of the player's third card, as seen by the dealer rule.
    always_comb begin
        p3_val = 4'd0;
        if (pcard3 >= 4'd1 && pcard3 <= 4'd9)
            p3_val = pcard3;
    end

    // Dealer drawing rule after the player took a third card. Any dealer score
    // of 7 or above (including out-of-range codes) stands.
    always_comb begin
        dealer_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (p3_val != 4'd8);
            4'd4:             dealer_draws = (p3_val >= 4'd2) && (p3_val <= 4'd7);
            4'd5:             dealer_draws = (p3_val >= 4'd4) && (p3_val <= 4'd7);
            4'd6:             dealer_draws = (p3_val >= 4'd6) && (p3_val <= 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    end

    // State register; reset lands in S_IDLE immediately, dropping any strobe.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. Scores are only looked at in S_EVAL and S_CHK3, the
    // cycles after the datapath has latched the relevant card.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_P1;
            S_P1:   state_nxt = S_D1;
            S_D1:   state_nxt = S_P2;
            S_P2:   state_nxt = S_D2;
            S_D2:   state_nxt = S_EVAL;
            S_EVAL: begin
                // Natural check first; out-of-range scores also end the hand.
                if (pscore >= 4'd8 || dscore >= 4'd8)
                    state_nxt = S_DONE;
                else if (pscore <= 4'd5)
                    state_nxt = S_P3;
                else if (dscore <= 4'd5)
                    state_nxt = S_D3;
                else
                    state_nxt = S_DONE;
            end
            S_P3:   state_nxt = S_CHK3;
            S_CHK3: state_nxt = dealer_draws ? S_D3 : S_DONE;
            S_D3:   state_nxt = S_DONE;
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode: strobes are one-hot by state; lights only in S_DONE.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        hand_done        = 1'b0;
        case (state)
            S_P1: load_pcard1 = 1'b1;
            S_D1: load_dcard1 = 1'b1;
            S_P2: load_pcard2 = 1'b1;
            S_D2: load_dcard2 = 1'b1;
            S_P3: load_pcard3 = 1'b1;
            S_D3: load_dcard3 = 1'b1;
            S_DONE: begin
                hand_done        = 1'b1;
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Scoreboard bench: each hand's expected per-cycle output trace is generated
// from the Punto Banco rules and queued, then popped and compared cycle by cycle.
module tb_baccarat_sequencer;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, hand_done;

    // {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin, done}
    localparam logic [8:0] V_P1   = 9'b100000000;
    localparam logic [8:0] V_D1   = 9'b010000000;
    localparam logic [8:0] V_P2   = 9'b001000000;
    localparam logic [8:0] V_D2   = 9'b000100000;
    localparam logic [8:0] V_P3   = 9'b000010000;
    localparam logic [8:0] V_D3   = 9'b000001000;
    localparam logic [8:0] V_NONE = 9'b000000000;

    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    baccarat_sequencer dut (
        .slow_clock      (slow_clock),
        .resetb          (resetb),
        .pscore          (pscore),
        .dscore          (dscore),
        .pcard3          (pcard3),
        .load_pcard1     (load_pcard1),
        .load_pcard2     (load_pcard2),
        .load_pcard3     (load_pcard3),
        .load_dcard1     (load_dcard1),
        .load_dcard2     (load_dcard2),
        .load_dcard3     (load_dcard3),
        .player_win_light(player_win_light),
        .dealer_win_light(dealer_win_light),
        .hand_done       (hand_done)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    function automatic logic [8:0] outs();
        return {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                load_pcard3, load_dcard3, player_win_light, dealer_win_light,
                hand_done};
    endfunction

    // Banker third-card table indexed by banker total, bit v set = draw.
    function automatic bit banker_draws(input int d, input int v);
        logic [9:0] tbl [0:7];
        tbl[0] = 10'h3FF; tbl[1] = 10'h3FF; tbl[2] = 10'h3FF;
        tbl[3] = 10'h2FF;            // all but 8
        tbl[4] = 10'b0011111100;     // 2..7
        tbl[5] = 10'b0011110000;     // 4..7
        tbl[6] = 10'b0011000000;     // 6..7
        tbl[7] = 10'h000;
        if (d > 7) return 1'b0;
        return tbl[d][v];
    endfunction

    // Push the expected per-edge output trace for one hand with constant inputs.
    task automatic push_hand(input int p, input int d, input int c3, input int extra);
        int v;
        logic [8:0] done_v;
        exp_q.push_back(V_P1);
        exp_q.push_back(V_D1);
        exp_q.push_back(V_P2);
        exp_q.push_back(V_D2);
        exp_q.push_back(V_NONE);                 // evaluation cycle
        if (!(p >= 8 || d >= 8)) begin
            if (p <= 5) begin
                exp_q.push_back(V_P3);
                exp_q.push_back(V_NONE);         // third-card check cycle
                v = (c3 >= 1 && c3 <= 9) ? c3 : 0;
                if (banker_draws(d, v)) exp_q.push_back(V_D3);
            end else if (d <= 5) begin
                exp_q.push_back(V_D3);
            end
        end
        done_v = {6'b0, (p >= d), (d >= p), 1'b1};
        for (int i = 0; i <= extra; i++) exp_q.push_back(done_v);
    endtask

    // Pop and compare one entry per rising edge, sampling on the falling edge.
    task automatic drain(input string name);
        logic [8:0] e, g;
        int cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge slow_clock);
            @(negedge slow_clock);
            cyc++;
            e = exp_q.pop_front();
            g = outs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s edge%0d: got %b expected %b", name, cyc, g, e);
            end
        end
    endtask

    task automatic reset_and_set(input string name, input int p, input int d, input int c3);
        @(negedge slow_clock);
        resetb = 1'b0;
        pscore = 4'(p); dscore = 4'(d); pcard3 = 4'(c3);
        #1;
        n_cmp++;
        if (outs() !== V_NONE) begin
            n_err++;
            $display("FAIL %s reset: got %b expected %b", name, outs(), V_NONE);
        end
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    task automatic run_hand(input string name, input int p, input int d, input int c3);
        reset_and_set(name, p, d, c3);
        push_hand(p, d, c3, 2);
        drain(name);
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
        repeat (2) @(negedge slow_clock);
        n_cmp++;
        if (outs() !== V_NONE) begin
            n_err++;
            $display("FAIL reset_idle: got %b expected %b", outs(), V_NONE);
        end
    endtask

    task automatic test_natural();
        run_hand("natural_p8_d3", 8, 3, 0);
        run_hand("natural_d9", 3, 9, 0);
        run_hand("out_of_range_p12", 12, 2, 5);
    endtask

    task automatic test_player_draws();
        run_hand("p4_d4_c7", 4, 4, 7);
        run_hand("p4_d4_c8", 4, 4, 8);
        run_hand("p0_d0_c0", 0, 0, 0);
        run_hand("p5_d6_c6", 5, 6, 6);
        run_hand("p5_d7_c6", 5, 7, 6);
    endtask

    task automatic test_face_value();
        run_hand("p2_d3_c12", 2, 3, 12);
        run_hand("p2_d3_c8", 2, 3, 8);
        run_hand("p1_d5_c15", 1, 5, 15);
    endtask

    task automatic test_player_stands();
        run_hand("p7_d5", 7, 5, 0);
        run_hand("p7_d6", 7, 6, 0);
    endtask

    task automatic test_tie_and_lights();
        run_hand("tie_6_6", 6, 6, 0);
        // Still in S_DONE: lights follow score changes combinationally.
        pscore = 4'd2;
        #1;
        n_cmp++;
        if (outs() !== 9'b000000011) begin
            n_err++;
            $display("FAIL lights_dealer: got %b expected %b", outs(), 9'b000000011);
        end
        pscore = 4'd9;
        #1;
        n_cmp++;
        if (outs() !== 9'b000000101) begin
            n_err++;
            $display("FAIL lights_player: got %b expected %b", outs(), 9'b000000101);
        end
    endtask

    task automatic test_reset_midhand();
        reset_and_set("midhand", 4, 4, 7);
        repeat (3) @(posedge slow_clock);
        @(negedge slow_clock);
        n_cmp++;
        if (outs() !== V_P2) begin
            n_err++;
            $display("FAIL midhand_p2: got %b expected %b", outs(), V_P2);
        end
        #1 resetb = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== V_NONE) begin
            n_err++;
            $display("FAIL midhand_async: got %b expected %b", outs(), V_NONE);
        end
        @(negedge slow_clock);
        resetb = 1'b1;
        push_hand(4, 4, 7, 1);
        drain("midhand_restart");
    endtask

    initial begin
        test_reset();
        test_natural();
        test_player_draws();
        test_face_value();
        test_player_stands();
        test_tie_and_lights();
        test_reset_midhand();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
